// File: rtl/mips_16_prog_loader_pkg.sv
// mips_16_prog_loader_pkg: shared widths and loader FSM state encodings.
// Default widths must match mips_16_core_top. States are plain 3-bit codes.
// The five byte-accepting states are kept numerically below DONE/ERR.
package mips_16_prog_loader_pkg;
    localparam int DEF_PC_WIDTH    = 8;
    localparam int DEF_INSTR_WIDTH = 16;
    localparam int DEF_IMEM_DEPTH  = 256;
    localparam logic [2:0] S_LEN_HI  = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ERR     = 3'd6;
endpackage

// File: rtl/mips_16_prog_loader_if.sv
// mips_16_prog_loader_if: 8-bit valid/ready byte stream feeding the loader.
// Signals:
//   in_data  - stream byte (master -> slave)
//   in_valid - in_data is valid (master -> slave)
//   in_ready - slave takes the byte this cycle (slave -> master)
interface mips_16_prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/mips_16_frame_xor.sv
// mips_16_frame_xor: byte-wide running XOR over the frame bytes.
// Ports:
//   clk - clock
//   clr - synchronous clear to zero, wins over en
//   en  - fold din into the accumulator
//   din - byte to fold in
//   acc - current XOR of all folded bytes
module mips_16_frame_xor (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    always_ff @(posedge clk)
        acc <= clr ? 8'd0 : en ? acc ^ din : acc;
endmodule

// File: rtl/mips_16_prog_loader.sv
// mips_16_prog_loader: loads a framed program image from a byte stream into
// the instruction memory and holds the core in reset until the load is done.
// Frame layout: LEN_HI LEN_LO {HI LO} x LEN CHK. CHK is the XOR of all prior bytes.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start      - one-cycle pulse that aborts any load and re-arms
//   stream     - byte stream slave (in_data / in_valid / in_ready)
//   imem_we    - one-cycle write strobe into instruction memory
//   imem_addr  - write word address
//   imem_wdata - write word
//   core_rst   - reset for the core, low only in DONE
//   load_done  - high in DONE
//   load_err   - high in ERR
module mips_16_prog_loader
    import mips_16_prog_loader_pkg::*;
#(
    parameter int PC_WIDTH    = DEF_PC_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int IMEM_DEPTH  = DEF_IMEM_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mips_16_prog_loader_if.slave   stream,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    output logic                   load_done,
    output logic                   load_err
);
    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [15:0] len_full;
    logic [7:0]  hi;
    logic [7:0]  xor_acc;
    logic        accept;
    logic        chk_ok;

    // Ready comes from registered state only. It is also dropped while rst or
    // start is high, because a byte offered in those cycles is discarded.
    assign stream.in_ready = !rst && !start && (state <= S_CHK);
    assign accept   = stream.in_valid && stream.in_ready;
    assign len_full = {len[15:8], stream.in_data};
    assign cnt_nxt  = cnt + 16'd1;
    assign chk_ok   = stream.in_data == xor_acc;

    // The checksum byte itself is not folded in; it is compared against the fold.
    mips_16_frame_xor u_xor (
        .clk(clk),
        .clr(rst || start),
        .en (accept && state != S_CHK),
        .din(stream.in_data),
        .acc(xor_acc)
    );

    always_ff @(posedge clk) begin
        if (rst || start) begin
            state     <= S_LEN_HI;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt       <= '0;
            imem_we   <= 1'b0;
            if (rst) begin
                imem_addr  <= '0;
                imem_wdata <= '0;
                len        <= '0;
                hi         <= '0;
            end
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_LEN_HI: begin
                        len[15:8] <= stream.in_data;
                        state     <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len[7:0] <= stream.in_data;
                        load_err <= int'(len_full) > IMEM_DEPTH;
                        state    <= int'(len_full) > IMEM_DEPTH ? S_ERR :
                                    len_full == 16'd0 ? S_CHK : S_DATA_HI;
                    end
                    S_DATA_HI: begin
                        hi    <= stream.in_data;
                        state <= S_DATA_LO;
                    end
                    S_DATA_LO: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= PC_WIDTH'(cnt);
                        imem_wdata <= INSTR_WIDTH'({hi, stream.in_data});
                        cnt        <= cnt_nxt;
                        state      <= cnt_nxt == len ? S_CHK : S_DATA_HI;
                    end
                    S_CHK: begin
                        state     <= chk_ok ? S_DONE : S_ERR;
                        load_done <= chk_ok;
                        load_err  <= !chk_ok;
                        core_rst  <= !chk_ok;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_16_prog_loader.sv
// tb_mips_16_prog_loader: directed frames with a write scoreboard for mips_16_prog_loader.
module tb_mips_16_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst;
    logic        load_done;
    logic        load_err;

    mips_16_prog_loader_if stream();

    mips_16_prog_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stream(stream),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] words[$];
    logic [7:0]  exp_addr;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and compare any write against the scoreboard head.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (imem_we) begin
            if (exp_q.size() == 0)
                chk("unexpected_we", 32'(imem_we), 0);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", 32'(imem_wdata), 32'(e.data));
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int n;
        ok = 1'b0;
        n = int'($urandom_range(gap, 0));
        repeat (n) tick();
        stream.in_data  = b;
        stream.in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = stream.in_ready;
            tick();
        end
        stream.in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'(ok), 1);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        exp_q.push_back({exp_addr, w});
        exp_addr++;
        send_byte(w[7:0], gap);
    endtask

    task automatic send_frame(input int gap, input logic [7:0] bad);
        logic [7:0]  x;
        logic [15:0] n;
        n = 16'(words.size());
        x = n[15:8] ^ n[7:0];
        exp_addr = 8'd0;
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (words[i]) begin
            x ^= words[i][15:8] ^ words[i][7:0];
            send_word(words[i], gap);
        end
        chk("pre_chk_core_rst", 32'(core_rst), 1);
        chk("pre_chk_done", 32'(load_done), 0);
        send_byte(x ^ bad, gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("start_done", 32'(load_done), 0);
        chk("start_err", 32'(load_err), 0);
        chk("start_core_rst", 32'(core_rst), 1);
        chk("start_ready", 32'(stream.in_ready), 1);
    endtask

    task automatic chk_done();
        chk("done", 32'(load_done), 1);
        chk("done_core_rst", 32'(core_rst), 0);
        chk("done_err", 32'(load_err), 0);
        chk("done_ready", 32'(stream.in_ready), 0);
        chk("q_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_err();
        chk("err", 32'(load_err), 1);
        chk("err_core_rst", 32'(core_rst), 1);
        chk("err_done", 32'(load_done), 0);
        chk("err_ready", 32'(stream.in_ready), 0);
        chk("q_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        stream.in_valid = 1'b0;
        stream.in_data  = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", 32'(imem_wdata), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_err", 32'(load_err), 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(stream.in_ready), 1);

        words = '{16'h1234, 16'hABCD};
        send_frame(0, 8'h00);
        chk_done();
        pulse_start();

        send_frame(0, 8'h01);
        chk_err();
        pulse_start();

        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk_err();
        repeat (3) tick();
        chk("oversize_err_held", 32'(load_err), 1);
        pulse_start();

        words = '{};
        send_frame(0, 8'h00);
        chk_done();
        pulse_start();

        words = '{16'h0102, 16'hF00D, 16'h8001, 16'h7FFE};
        send_frame(3, 8'h00);
        chk_done();
        pulse_start();

        exp_addr = 8'd0;
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        start = 1'b1;
        stream.in_data  = 8'h55;
        stream.in_valid = 1'b1;
        #1;
        chk("ready_during_start", 32'(stream.in_ready), 0);
        tick();
        start = 1'b0;
        stream.in_valid = 1'b0;
        #1;
        chk("abort_core_rst", 32'(core_rst), 1);
        chk("abort_ready", 32'(stream.in_ready), 1);
        chk("abort_q_empty", 32'(exp_q.size()), 0);
        words = '{16'hBEEF, 16'hCAFE};
        send_frame(0, 8'h00);
        chk_done();
        pulse_start();

        exp_addr = 8'd0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'h1357, 0);
        send_byte(8'h24, 0);
        rst = 1'b1;
        stream.in_data  = 8'h68;
        stream.in_valid = 1'b1;
        tick();
        rst = 1'b0;
        stream.in_valid = 1'b0;
        #1;
        chk("midrst_we", 32'(imem_we), 0);
        chk("midrst_addr", 32'(imem_addr), 0);
        chk("midrst_wdata", 32'(imem_wdata), 0);
        chk("midrst_core_rst", 32'(core_rst), 1);
        chk("midrst_done", 32'(load_done), 0);
        chk("midrst_err", 32'(load_err), 0);
        chk("midrst_ready", 32'(stream.in_ready), 1);
        words = '{16'h2105, 16'h2207, 16'h0312, 16'h4000, 16'hE000};
        send_frame(1, 8'h00);
        chk_done();
        repeat (3) tick();
        chk("done_held", 32'(load_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
